// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one prescaled countdown timer between N_REQ clients.
// The owner keeps the grant while its tick count runs down and receives a one-cycle done pulse.
module timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic [7:0]             prescaler_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*CNT_W-1:0] ticks_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       done_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       remaining_o
);

    // state | meaning
    // IDLE  | no owner; arbitrate when enabled and any request is pending
    // RUN   | owner granted, prescaled countdown in progress
    // DONE  | one-cycle completion pulse to the owner
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [7:0]         ps_q, ps_d;
    logic [7:0]         p_q, p_d;

    logic [IDX_W-1:0]   win_idx;
    logic [CNT_W-1:0]   win_ticks;
    int                 cand;

    // Scan downward so the last hit is the nearest set bit after ptr; ptr doubles as owner index.
    always_comb begin
        win_idx = ptr_q;
        cand    = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = (int'(ptr_q) + i) % N_REQ;
            if (req_i[cand]) begin
                win_idx = IDX_W'(cand);
            end
        end
    end

    assign win_ticks = ticks_i[int'(win_idx)*CNT_W +: CNT_W];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(N_REQ - 1);
            rem_q   <= '0;
            ps_q    <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            ps_q    <= ps_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        ps_d    = ps_q;
        p_d     = p_q;

        unique case (state_q)
            IDLE: begin
                if (en_i && |req_i) begin
                    ptr_d   = win_idx;
                    rem_d   = win_ticks;
                    p_d     = prescaler_i;
                    ps_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Cancel wins over a coincident final tick.
                if (!req_i[ptr_q]) begin
                    rem_d   = '0;
                    ps_d    = '0;
                    state_d = IDLE;
                end else if (rem_q == '0) begin
                    state_d = DONE;
                end else if (en_i) begin
                    if (ps_q == p_q) begin
                        ps_d  = '0;
                        rem_d = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_d = DONE;
                        end
                    end else begin
                        ps_d = ps_q + 8'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_o       = (state_q == RUN)  ? (N_REQ'(1) << ptr_q) : '0;
    assign done_o      = (state_q == DONE) ? (N_REQ'(1) << ptr_q) : '0;
    assign busy_o      = (state_q == RUN) || (state_q == DONE);
    assign remaining_o = rem_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: hand-computed grant/done timing, round-robin order,
// enable freeze, cancel priority and mid-run reset.
module tb_timer_arbiter;

    localparam int N_REQ = 4;
    localparam int CNT_W = 16;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   en_i;
    logic [7:0]             prescaler_i;
    logic [N_REQ-1:0]       req_i;
    logic [N_REQ*CNT_W-1:0] ticks_i;
    logic [N_REQ-1:0]       gnt_o;
    logic [N_REQ-1:0]       done_o;
    logic                   busy_o;
    logic [CNT_W-1:0]       remaining_o;

    int checks = 0;
    int errors = 0;

    timer_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .prescaler_i (prescaler_i),
        .req_i       (req_i),
        .ticks_i     (ticks_i),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .busy_o      (busy_o),
        .remaining_o (remaining_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
    endtask

    task automatic set_ticks(input int k, input logic [CNT_W-1:0] t);
        ticks_i[k*CNT_W +: CNT_W] = t;
    endtask

    // Counts cycles from the current (grant) cycle until done_o is seen.
    task automatic cycles_to_done(input int max_cycles, output int n);
        n = 0;
        while (done_o == '0 && n < max_cycles) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        rst_ni      = 1'b0;
        en_i        = 1'b1;
        prescaler_i = 8'd0;
        req_i       = '0;
        ticks_i     = '0;
        step();
        step();
        check("reset_gnt",  32'(gnt_o), 32'h0);
        check("reset_done", 32'(done_o), 32'h0);
        check("reset_busy", 32'(busy_o), 32'h0);
        check("reset_rem",  32'(remaining_o), 32'h0);
        rst_ni = 1'b1;
        step();

        // Basic run: P=2, T=3 -> 9 grant cycles, done at G+9
        prescaler_i = 8'd2;
        set_ticks(0, 16'd3);
        req_i = 4'b0001;
        step();
        for (int k = 0; k < 9; k++) begin
            check("basic_gnt",  32'(gnt_o), 32'h1);
            check("basic_done", 32'(done_o), 32'h0);
            check("basic_rem",  32'(remaining_o), 32'(3 - k / 3));
            step();
        end
        check("basic_done_pulse", 32'(done_o), 32'h1);
        check("basic_done_gnt",   32'(gnt_o), 32'h0);
        check("basic_done_busy",  32'(busy_o), 32'h1);
        check("basic_done_rem",   32'(remaining_o), 32'h0);
        req_i = '0;
        step();
        check("basic_idle_busy", 32'(busy_o), 32'h0);
        check("basic_idle_done", 32'(done_o), 32'h0);

        // Round-robin: all ticks=1, P=0, all requesting
        do_reset();
        prescaler_i = 8'd0;
        for (int k = 0; k < N_REQ; k++) set_ticks(k, 16'd1);
        req_i = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            check("rr_gnt", 32'(gnt_o), 32'(1 << (k % 4)));
            step();
            check("rr_done", 32'(done_o), 32'(1 << (k % 4)));
            check("rr_done_gnt", 32'(gnt_o), 32'h0);
            step();
            check("rr_idle_busy", 32'(busy_o), 32'h0);
            step();
        end
        req_i = '0;
        step();
        check("rr_cancel_busy", 32'(busy_o), 32'h0);

        // Zero ticks: done at G+1
        do_reset();
        prescaler_i = 8'd3;
        set_ticks(0, 16'd0);
        req_i = 4'b0001;
        step();
        check("zero_gnt", 32'(gnt_o), 32'h1);
        check("zero_rem", 32'(remaining_o), 32'h0);
        step();
        check("zero_done", 32'(done_o), 32'h1);
        req_i = '0;
        step();

        // Prescaler bypass: P=0, ticks=5 -> done at G+5 (requester 1 wins after reset only if alone)
        do_reset();
        prescaler_i = 8'd0;
        set_ticks(1, 16'd5);
        req_i = 4'b0010;
        step();
        check("byp_gnt", 32'(gnt_o), 32'h2);
        check("byp_rem", 32'(remaining_o), 32'd5);
        cycles_to_done(20, n);
        check("byp_latency", 32'(n), 32'd5);
        check("byp_done", 32'(done_o), 32'h2);
        req_i = '0;
        step();

        // Enable freeze: P=1, T=2, en low for 4 cycles -> done at G+8
        do_reset();
        prescaler_i = 8'd1;
        set_ticks(0, 16'd2);
        req_i = 4'b0001;
        step();
        check("frz_rem_g0", 32'(remaining_o), 32'd2);
        step();
        check("frz_rem_g1", 32'(remaining_o), 32'd2);
        step();
        check("frz_rem_g2", 32'(remaining_o), 32'd1);
        en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("frz_hold_rem", 32'(remaining_o), 32'd1);
            check("frz_hold_gnt", 32'(gnt_o), 32'h1);
        end
        en_i = 1'b1;
        step();
        check("frz_g7_done", 32'(done_o), 32'h0);
        check("frz_g7_gnt",  32'(gnt_o), 32'h1);
        step();
        check("frz_g8_done", 32'(done_o), 32'h1);
        en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("frz_idle_gnt",  32'(gnt_o), 32'h0);
            check("frz_idle_busy", 32'(busy_o), 32'h0);
        end
        en_i = 1'b1;
        step();
        check("frz_regrant", 32'(gnt_o), 32'h1);
        req_i = '0;
        step();

        // Cancel coincident with final tick
        do_reset();
        prescaler_i = 8'd0;
        set_ticks(0, 16'd1);
        set_ticks(1, 16'd2);
        req_i = 4'b0011;
        step();
        check("cxl_gnt", 32'(gnt_o), 32'h1);
        req_i = 4'b0010;
        step();
        check("cxl_done", 32'(done_o), 32'h0);
        check("cxl_busy", 32'(busy_o), 32'h0);
        check("cxl_rem",  32'(remaining_o), 32'h0);
        step();
        check("cxl_next_gnt", 32'(gnt_o), 32'h2);
        check("cxl_next_rem", 32'(remaining_o), 32'd2);
        req_i = '0;
        step();

        // Reset mid-run: pointer returns so index 0 wins again
        do_reset();
        prescaler_i = 8'd3;
        set_ticks(0, 16'd5);
        set_ticks(1, 16'd5);
        req_i = 4'b0001;
        step();
        check("rst_run_gnt", 32'(gnt_o), 32'h1);
        step();
        step();
        rst_ni = 1'b0;
        req_i  = 4'b0011;
        step();
        check("rst_mid_gnt",  32'(gnt_o), 32'h0);
        check("rst_mid_done", 32'(done_o), 32'h0);
        check("rst_mid_busy", 32'(busy_o), 32'h0);
        check("rst_mid_rem",  32'(remaining_o), 32'h0);
        rst_ni = 1'b1;
        step();
        check("rst_regrant", 32'(gnt_o), 32'h1);
        check("rst_regrant_rem", 32'(remaining_o), 32'd5);
        req_i = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
